// File: rtl/song_reader_seq_if.sv
// Bundle between the song sequencer, its note ROM, and the note player.
// The sequencer uses the master view; the testbench or the surrounding logic uses the slave view.
interface song_reader_seq_if #(
   parameter int SONG_BITS = 2,
   parameter int IDX_BITS  = 5,
   parameter int NOTE_W    = 6,
   parameter int DUR_W     = 6
);
   logic                          play;
   logic                          stop;
   logic [SONG_BITS-1:0]          song_sel;
   logic                          loop_en;
   logic                          note_done;
   logic [NOTE_W+DUR_W-1:0]       rom_data;
   logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
   logic [NOTE_W-1:0]             note;
   logic [DUR_W-1:0]              duration;
   logic                          new_note;
   logic                          song_done;
   logic                          busy;

   modport master (
      input  play, stop, song_sel, loop_en, note_done, rom_data,
      output rom_addr, note, duration, new_note, song_done, busy
   );

   modport slave (
      output play, stop, song_sel, loop_en, note_done, rom_data,
      input  rom_addr, note, duration, new_note, song_done, busy
   );
endinterface

// File: rtl/song_reader_seq.sv
// Steps through the note slots of one song in a synchronous ROM and hands each
// {note, duration} to the note player. It supports pause, abort and looping.
//
// state  | meaning
// IDLE   | no song active; play latches song_sel and starts at slot 0
// FETCH  | rom_addr presented, ROM data arrives at the next edge
// ISSUE  | ROM word valid; nonzero duration issues a note, zero ends the song
// WAIT   | note playing; note_done advances, play=0 pauses
// PAUSED | holding position; note_done ignored until play returns
// END    | song_done pulse; loop back to slot 0 or return to IDLE
module song_reader_seq #(
   parameter int SONG_BITS = 2,
   parameter int IDX_BITS  = 5,
   parameter int NOTE_W    = 6,
   parameter int DUR_W     = 6
) (
   input logic              clk,
   input logic              reset,
   song_reader_seq_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_PAUSED = 3'd4,
      S_END    = 3'd5
   } state_t;

   localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

   state_t               state_q, state_d;
   logic [SONG_BITS-1:0] song_q, song_d;
   logic [IDX_BITS-1:0]  idx_q, idx_d;
   logic [NOTE_W-1:0]    note_q, note_d;
   logic [DUR_W-1:0]     dur_q, dur_d;
   logic                 new_note_q, new_note_d;
   logic                 song_done_q, song_done_d;

   logic [NOTE_W-1:0]    rom_note;
   logic [DUR_W-1:0]     rom_dur;

   assign {rom_note, rom_dur} = bus.rom_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         song_q      <= '0;
         idx_q       <= '0;
         note_q      <= '0;
         dur_q       <= '0;
         new_note_q  <= 1'b0;
         song_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         song_q      <= song_d;
         idx_q       <= idx_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         new_note_q  <= new_note_d;
         song_done_q <= song_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      song_d      = song_q;
      idx_d       = idx_q;
      note_d      = note_q;
      dur_d       = dur_q;
      new_note_d  = 1'b0;
      song_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.play) begin
               song_d  = bus.song_sel;
               idx_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (rom_dur != '0) begin
               note_d     = rom_note;
               dur_d      = rom_dur;
               new_note_d = 1'b1;
               state_d    = S_WAIT;
            end else begin
               song_done_d = 1'b1;
               state_d     = S_END;
            end
         end
         S_WAIT: begin
            // note_done outranks a simultaneous pause request
            if (bus.note_done) begin
               if (idx_q == IDX_LAST) begin
                  song_done_d = 1'b1;
                  state_d     = S_END;
               end else begin
                  idx_d   = idx_q + IDX_BITS'(1);
                  state_d = S_FETCH;
               end
            end else if (!bus.play) begin
               state_d = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (bus.play) begin
               state_d = S_WAIT;
            end
         end
         S_END: begin
            if (bus.loop_en) begin
               idx_d   = '0;
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // abort wins over everything once a song is active
      if (bus.stop && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         idx_d       = idx_q;
         note_d      = note_q;
         dur_d       = dur_q;
         new_note_d  = 1'b0;
         song_done_d = 1'b0;
      end
   end

   assign bus.rom_addr  = {song_q, idx_q};
   assign bus.note      = note_q;
   assign bus.duration  = dur_q;
   assign bus.new_note  = new_note_q;
   assign bus.song_done = song_done_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_song_reader_seq.sv
// Bench for song_reader_seq: vector table, directed multi-cycle sequences and a
// randomized run, all compared against a slot/countdown reference model.
module tb_song_reader_seq;

   localparam int SB    = 2;
   localparam int IB    = 5;
   localparam int NW    = 6;
   localparam int DW    = 6;
   localparam int NSLOT = 1 << IB;
   localparam int NROM  = (1 << SB) * NSLOT;

   logic clk;
   logic reset;
   logic [NW+DW-1:0] rom [0:NROM-1];

   int checks   = 0;
   int failures = 0;

   song_reader_seq_if #(.SONG_BITS(SB), .IDX_BITS(IB), .NOTE_W(NW), .DUR_W(DW)) bus ();

   song_reader_seq #(.SONG_BITS(SB), .IDX_BITS(IB), .NOTE_W(NW), .DUR_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   // reference model: song position plus a countdown until the ROM word is used
   bit m_active, m_paused, m_ending, m_nn, m_sd;
   int m_pend, m_idx, m_song, m_note, m_dur;

   task automatic model_step();
      int word;
      m_nn = 0;
      m_sd = 0;
      if (reset) begin
         m_active = 0; m_paused = 0; m_ending = 0; m_pend = 0;
         m_idx = 0; m_song = 0; m_note = 0; m_dur = 0;
      end else if (m_active && bus.stop) begin
         m_active = 0; m_paused = 0; m_ending = 0; m_pend = 0;
      end else if (!m_active) begin
         if (bus.play) begin
            m_active = 1; m_song = int'(bus.song_sel); m_idx = 0; m_pend = 2;
         end
      end else if (m_pend > 0) begin
         m_pend--;
         if (m_pend == 0) begin
            word = int'(rom[m_song * NSLOT + m_idx]);
            if (word % (1 << DW) != 0) begin
               m_note = word / (1 << DW);
               m_dur  = word % (1 << DW);
               m_nn   = 1;
            end else begin
               m_ending = 1;
               m_sd     = 1;
            end
         end
      end else if (m_ending) begin
         m_ending = 0;
         if (bus.loop_en) begin
            m_idx = 0; m_pend = 2;
         end else begin
            m_active = 0;
         end
      end else if (m_paused) begin
         if (bus.play) m_paused = 0;
      end else if (bus.note_done) begin
         if (m_idx == NSLOT - 1) begin
            m_ending = 1; m_sd = 1;
         end else begin
            m_idx++; m_pend = 2;
         end
      end else if (!bus.play) begin
         m_paused = 1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("model_rom_addr", int'(bus.rom_addr), m_song * NSLOT + m_idx);
      chk("model_new_note", int'(bus.new_note), int'(m_nn));
      chk("model_song_done", int'(bus.song_done), int'(m_sd));
      chk("model_busy", int'(bus.busy), int'(m_active));
      chk("model_note", int'(bus.note), m_note);
      chk("model_duration", int'(bus.duration), m_dur);
      if (bus.new_note && bus.song_done) chk("pulse_overlap", 1, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic set_in(input bit rs, input bit pl, input bit st, input bit nd,
                         input bit lp, input int sel);
      reset         = rs;
      bus.play      = pl;
      bus.stop      = st;
      bus.note_done = nd;
      bus.loop_en   = lp;
      bus.song_sel  = SB'(sel);
   endtask

   typedef struct {
      bit rst, play, stp, nd, lp;
      int sel;
      int addr;
      bit nn, sd, bsy;
      int note, dur;
   } vec_t;

   vec_t tbl [16];

   int cnt_nn, cnt_sd;
   bit seen;

   initial begin
      for (int i = 0; i < NROM; i++) rom[i] = 12'(((i * 7 + 3) % 64) * 64 + (i % 63) + 1);
      rom['h40] = {6'd5, 6'd8};
      rom['h41] = {6'd9, 6'd3};
      rom['h42] = {6'd12, 6'd4};
      rom['h43] = {6'd33, 6'd0};
      for (int i = 0; i < NSLOT; i++) rom['h20 + i] = 12'(((i * 3 + 1) % 64) * 64 + i + 1);

      //         rst play stp nd lp sel  addr nn sd bsy note dur
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 0, 2, 'h40, 0, 0, 1, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 0, 0, 'h40, 0, 0, 1, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, 0, 0, 'h40, 1, 0, 1, 5, 8};
      tbl[4]  = '{0, 1, 0, 0, 0, 0, 'h40, 0, 0, 1, 5, 8};
      tbl[5]  = '{0, 0, 0, 0, 0, 0, 'h40, 0, 0, 1, 5, 8};
      tbl[6]  = '{0, 0, 0, 1, 0, 0, 'h40, 0, 0, 1, 5, 8};
      tbl[7]  = '{0, 1, 0, 0, 0, 0, 'h40, 0, 0, 1, 5, 8};
      tbl[8]  = '{0, 0, 0, 1, 0, 0, 'h41, 0, 0, 1, 5, 8};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 'h41, 0, 0, 1, 5, 8};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 'h41, 1, 0, 1, 9, 3};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 'h41, 0, 0, 1, 9, 3};
      tbl[12] = '{0, 0, 1, 0, 0, 0, 'h41, 0, 0, 0, 9, 3};
      tbl[13] = '{0, 1, 0, 0, 0, 2, 'h40, 0, 0, 1, 9, 3};
      tbl[14] = '{0, 1, 1, 0, 0, 2, 'h40, 0, 0, 0, 9, 3};
      tbl[15] = '{0, 0, 0, 0, 0, 2, 'h40, 0, 0, 0, 9, 3};

      set_in(1, 0, 0, 0, 0, 0);
      for (int v = 0; v < 16; v++) begin
         set_in(tbl[v].rst, tbl[v].play, tbl[v].stp, tbl[v].nd, tbl[v].lp, tbl[v].sel);
         tick();
         chk($sformatf("vec%0d_addr", v), int'(bus.rom_addr), tbl[v].addr);
         chk($sformatf("vec%0d_new_note", v), int'(bus.new_note), int'(tbl[v].nn));
         chk($sformatf("vec%0d_song_done", v), int'(bus.song_done), int'(tbl[v].sd));
         chk($sformatf("vec%0d_busy", v), int'(bus.busy), int'(tbl[v].bsy));
         chk($sformatf("vec%0d_note", v), int'(bus.note), tbl[v].note);
         chk($sformatf("vec%0d_dur", v), int'(bus.duration), tbl[v].dur);
      end

      // end marker at slot 3 of song 2, no loop
      set_in(1, 0, 0, 0, 0, 0); tick();
      set_in(0, 1, 0, 0, 0, 2);
      cnt_nn = 0; cnt_sd = 0; seen = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         cnt_nn += int'(bus.new_note);
         cnt_sd += int'(bus.song_done);
         bus.note_done = bus.new_note;
         if (cnt_sd > 0 && !bus.busy) begin seen = 1; break; end
      end
      chk("endmark_done_in_time", int'(seen), 1);
      chk("endmark_new_notes", cnt_nn, 3);
      chk("endmark_song_done", cnt_sd, 1);
      chk("endmark_busy", int'(bus.busy), 0);

      // full 32-note song 1 with looping
      set_in(1, 0, 0, 0, 0, 0); tick();
      set_in(0, 1, 0, 0, 1, 1);
      cnt_nn = 0; seen = 0;
      for (int c = 0; c < 400; c++) begin
         tick();
         cnt_nn += int'(bus.new_note);
         bus.note_done = bus.new_note;
         if (bus.song_done) begin seen = 1; break; end
      end
      chk("loop_done_in_time", int'(seen), 1);
      chk("loop_new_notes", cnt_nn, 32);
      bus.note_done = 0;
      tick();
      chk("loop_addr_back", int'(bus.rom_addr), 'h20);
      chk("loop_nn_c1", int'(bus.new_note), 0);
      tick();
      chk("loop_nn_c2", int'(bus.new_note), 0);
      tick();
      chk("loop_nn_c3", int'(bus.new_note), 1);
      chk("loop_note", int'(bus.note), 1);
      chk("loop_dur", int'(bus.duration), 1);
      bus.stop = 1; tick(); bus.stop = 0;
      chk("loop_stop_busy", int'(bus.busy), 0);

      // reset while waiting on slot 7
      set_in(1, 0, 0, 0, 0, 0); tick();
      set_in(0, 1, 0, 0, 0, 1);
      cnt_nn = 0;
      for (int c = 0; c < 100 && cnt_nn < 8; c++) begin
         tick();
         cnt_nn += int'(bus.new_note);
         bus.note_done = bus.new_note && (cnt_nn < 8);
      end
      chk("rst_reached_idx7", int'(bus.rom_addr), 'h27);
      tick(); tick();
      reset = 1; tick();
      chk("rst_addr", int'(bus.rom_addr), 0);
      chk("rst_note", int'(bus.note), 0);
      chk("rst_dur", int'(bus.duration), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_new_note", int'(bus.new_note), 0);
      reset = 0; bus.song_sel = 1; tick();
      chk("replay_addr", int'(bus.rom_addr), 'h20);
      tick(); tick();
      chk("replay_new_note", int'(bus.new_note), 1);
      chk("replay_note", int'(bus.note), 1);

      // randomized run against the model
      for (int i = 0; i < NROM; i++)
         rom[i] = {NW'($urandom), ($urandom_range(0, 9) == 0) ? DW'(0) : DW'($urandom_range(1, 63))};
      set_in(1, 0, 0, 0, 0, 0); tick(); tick();
      for (int c = 0; c < 4000; c++) begin
         set_in($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
